// File: rtl/flash_boot_loader_pkg.sv
// Shared widths and FSM state encoding for the flash-to-RAM boot copy engine.
package flash_boot_loader_pkg;

  localparam int unsigned FLASH_AW_DEF = 22;
  localparam int unsigned FLASH_DW     = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RD_LO  = 3'd1;
  localparam state_t ST_GAP_LO = 3'd2;
  localparam state_t ST_RD_HI  = 3'd3;
  localparam state_t ST_GAP_HI = 3'd4;
  localparam state_t ST_WR     = 3'd5;
  localparam state_t ST_DONE   = 3'd6;

endpackage

// File: rtl/flash_boot_loader.sv
// Boot copy engine: reads halfword pairs from the flash driver, packs them
// little-endian into 32-bit words and writes them to RAM, then flags done.
module flash_boot_loader
  import flash_boot_loader_pkg::*;
#(
  parameter int unsigned         FLASH_AW   = FLASH_AW_DEF,
  parameter int unsigned         RAM_AW     = 20,
  parameter int unsigned         WORDS      = 1024,
  parameter logic [FLASH_AW-1:0] FLASH_BASE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [FLASH_AW-1:0] flash_addr_o,
  output logic                flash_rd_en_o,
  input  logic [FLASH_DW-1:0] flash_data_i,
  input  logic                flash_rd_finish_i,
  output logic [RAM_AW-1:0]   ram_addr_o,
  output logic [31:0]         ram_data_o,
  output logic                ram_we_o,
  input  logic                ram_ack_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [RAM_AW:0]     word_cnt_o
);

  localparam logic [RAM_AW:0] WORDS_C = (RAM_AW + 1)'(WORDS);

  state_t              state_q, state_d;
  logic [FLASH_AW-1:0] ptr_q, ptr_d;
  logic [FLASH_DW-1:0] lo_q, lo_d;
  logic [FLASH_DW-1:0] hi_q, hi_d;
  logic [RAM_AW:0]     cnt_q, cnt_d;
  logic                commit_q, commit_d;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    commit_d = commit_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cnt_d    = '0;
          ptr_d    = FLASH_BASE;
          commit_d = 1'b0;
          state_d  = (WORDS == 0) ? ST_DONE : ST_RD_LO;
        end
      end
      ST_RD_LO: begin
        if (flash_rd_finish_i) begin
          lo_d    = flash_data_i;
          ptr_d   = ptr_q + FLASH_AW'(1);
          state_d = ST_GAP_LO;
        end
      end
      ST_GAP_LO: state_d = ST_RD_HI;
      ST_RD_HI: begin
        if (flash_rd_finish_i) begin
          hi_d    = flash_data_i;
          ptr_d   = ptr_q + FLASH_AW'(1);
          state_d = ST_GAP_HI;
        end
      end
      ST_GAP_HI: state_d = ST_WR;
      ST_WR: begin
        // WR spans a request phase and a one-cycle commit phase: the counter
        // is bumped on ack, and the loop/finish decision is taken from the
        // updated count on the following cycle with the write request dropped.
        if (!commit_q) begin
          if (ram_ack_i) begin
            cnt_d    = cnt_q + (RAM_AW + 1)'(1);
            commit_d = 1'b1;
          end
        end else begin
          commit_d = 1'b0;
          state_d  = (cnt_q == WORDS_C) ? ST_DONE : ST_RD_LO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
    end
  end

  assign flash_addr_o  = ptr_q;
  assign flash_rd_en_o = (state_q == ST_RD_LO) || (state_q == ST_RD_HI);
  assign ram_addr_o    = cnt_q[RAM_AW-1:0];
  assign ram_data_o    = {hi_q, lo_q};
  assign ram_we_o      = (state_q == ST_WR) && !commit_q;
  assign busy_o        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o        = (state_q == ST_DONE);
  assign word_cnt_o    = cnt_q;

endmodule
